// File: rtl/ycbcr_to_rgb.sv
`default_nettype none
// ============================================================================
// Module      : ycbcr_to_rgb
// Description : 4-stage pipelined BT.709 limited-range YCbCr 4:4:4 to RGB888
//               converter with h/v/de delayed in lockstep with the data.
// Revision    : 1.0 - initial release
// ============================================================================
module ycbcr_to_rgb #(
    parameter int K_Y    = 298,
    parameter int K_CR_R = 459,
    parameter int K_CB_G = 55,
    parameter int K_CR_G = 136,
    parameter int K_CB_B = 541
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_y_8b,
    input  logic [7:0] i_cb_8b,
    input  logic [7:0] i_cr_8b,
    input  logic       i_h_sync,
    input  logic       i_v_sync,
    input  logic       i_data_en,
    output logic [7:0] o_r_8b,
    output logic [7:0] o_g_8b,
    output logic [7:0] o_b_8b,
    output logic       o_h_sync,
    output logic       o_v_sync,
    output logic       o_data_en
);

    localparam int               c_DELAY = 4;
    localparam logic signed [19:0] c_ROUND = 20'sd128;

    logic signed [8:0]  r_yo, r_cbo, r_cro;
    logic signed [19:0] r_py, r_prr, r_pgb, r_pgr, r_pbb;
    logic signed [19:0] r_sr, r_sg, r_sb;
    logic [7:0]         r_r_8b, r_g_8b, r_b_8b;
    logic [c_DELAY-1:0] r_hs_dly, r_vs_dly, r_de_dly;

    // Sign bit means the scaled value is negative; any of bits 18:16 set
    // means it exceeds 255 after the >>8 scale.
    function automatic logic [7:0] clamp8(input logic signed [19:0] s);
        logic [7:0] v;
        if (s[19])
            v = 8'd0;
        else if (|s[18:16])
            v = 8'hFF;
        else
            v = s[15:8];
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_yo     <= '0;
            r_cbo    <= '0;
            r_cro    <= '0;
            r_py     <= '0;
            r_prr    <= '0;
            r_pgb    <= '0;
            r_pgr    <= '0;
            r_pbb    <= '0;
            r_sr     <= '0;
            r_sg     <= '0;
            r_sb     <= '0;
            r_r_8b   <= '0;
            r_g_8b   <= '0;
            r_b_8b   <= '0;
            r_hs_dly <= '0;
            r_vs_dly <= '0;
            r_de_dly <= '0;
        end else begin
            r_yo     <= $signed({1'b0, i_y_8b})  - 9'sd16;
            r_cbo    <= $signed({1'b0, i_cb_8b}) - 9'sd128;
            r_cro    <= $signed({1'b0, i_cr_8b}) - 9'sd128;

            r_py     <= 20'(r_yo  * K_Y);
            r_prr    <= 20'(r_cro * K_CR_R);
            r_pgb    <= 20'(r_cbo * K_CB_G);
            r_pgr    <= 20'(r_cro * K_CR_G);
            r_pbb    <= 20'(r_cbo * K_CB_B);

            r_sr     <= r_py + r_prr + c_ROUND;
            r_sg     <= r_py - r_pgb - r_pgr + c_ROUND;
            r_sb     <= r_py + r_pbb + c_ROUND;

            r_r_8b   <= clamp8(r_sr);
            r_g_8b   <= clamp8(r_sg);
            r_b_8b   <= clamp8(r_sb);

            r_hs_dly <= {r_hs_dly[c_DELAY-2:0], i_h_sync};
            r_vs_dly <= {r_vs_dly[c_DELAY-2:0], i_v_sync};
            r_de_dly <= {r_de_dly[c_DELAY-2:0], i_data_en};
        end
    end

    assign o_r_8b    = r_r_8b;
    assign o_g_8b    = r_g_8b;
    assign o_b_8b    = r_b_8b;
    assign o_h_sync  = r_hs_dly[c_DELAY-1];
    assign o_v_sync  = r_vs_dly[c_DELAY-1];
    assign o_data_en = r_de_dly[c_DELAY-1];

endmodule
`default_nettype wire

// File: tb/tb_ycbcr_to_rgb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ycbcr_to_rgb
// Description : Self-checking bench for ycbcr_to_rgb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ycbcr_to_rgb;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_y_8b, i_cb_8b, i_cr_8b;
    logic       i_h_sync, i_v_sync, i_data_en;
    logic [7:0] o_r_8b, o_g_8b, o_b_8b;
    logic       o_h_sync, o_v_sync, o_data_en;

    typedef struct {
        logic [7:0] y, cb, cr;
        logic [7:0] r, g, b;
    } vec_t;

    typedef struct {
        logic [7:0] r, g, b;
        logic       h, v, de;
        int         tag;
    } exp_t;

    vec_t tbl[15];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   pix_id   = 0;

    always #5 clk = ~clk;

    ycbcr_to_rgb dut (
        .clk       (clk),
        .rst       (rst),
        .i_y_8b    (i_y_8b),
        .i_cb_8b   (i_cb_8b),
        .i_cr_8b   (i_cr_8b),
        .i_h_sync  (i_h_sync),
        .i_v_sync  (i_v_sync),
        .i_data_en (i_data_en),
        .o_r_8b    (o_r_8b),
        .o_g_8b    (o_g_8b),
        .o_b_8b    (o_b_8b),
        .o_h_sync  (o_h_sync),
        .o_v_sync  (o_v_sync),
        .o_data_en (o_data_en)
    );

    function automatic logic [7:0] clip(input int s);
        int v;
        v = s >>> 8;
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    task automatic model(input logic [7:0] y, cb, cr, output logic [7:0] r, g, b);
        int yo, cbo, cro;
        yo  = int'(y)  - 16;
        cbo = int'(cb) - 128;
        cro = int'(cr) - 128;
        r = clip(298 * yo + 459 * cro + 128);
        g = clip(298 * yo - 55 * cbo - 136 * cro + 128);
        b = clip(298 * yo + 541 * cbo + 128);
    endtask

    task automatic check_out(input string name, input int tag,
                             input logic [7:0] er, eg, eb,
                             input logic eh, ev, ede);
        n_checks++;
        if ({o_r_8b, o_g_8b, o_b_8b, o_h_sync, o_v_sync, o_data_en} !==
            {er, eg, eb, eh, ev, ede}) begin
            n_errors++;
            $display("FAIL %s pix%0d: got rgb=%0d,%0d,%0d h/v/de=%b%b%b, expected rgb=%0d,%0d,%0d h/v/de=%b%b%b",
                     name, tag, o_r_8b, o_g_8b, o_b_8b, o_h_sync, o_v_sync, o_data_en,
                     er, eg, eb, eh, ev, ede);
        end
    endtask

    // Drives one pixel for one clock and checks whichever pixel is due out.
    task automatic push_pixel(input string name,
                              input logic [7:0] y, cb, cr,
                              input logic h, v, de,
                              input logic [7:0] er, eg, eb);
        exp_t e;
        i_y_8b    = y;
        i_cb_8b   = cb;
        i_cr_8b   = cr;
        i_h_sync  = h;
        i_v_sync  = v;
        i_data_en = de;
        e.r = er; e.g = eg; e.b = eb;
        e.h = h;  e.v = v;  e.de = de;
        e.tag = pix_id;
        pix_id++;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        if (exp_q.size() >= 4) begin
            e = exp_q.pop_front();
            check_out(name, e.tag, e.r, e.g, e.b, e.h, e.v, e.de);
        end else begin
            check_out("fill_zero", e.tag, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic push_model(input string name, input logic [7:0] y, cb, cr,
                              input logic h, v, de);
        logic [7:0] r, g, b;
        model(y, cb, cr, r, g, b);
        push_pixel(name, y, cb, cr, h, v, de, r, g, b);
    endtask

    initial begin
        tbl[0]  = '{8'd16,  8'd128, 8'd128, 8'd0,   8'd0,   8'd0};
        tbl[1]  = '{8'd235, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255};
        tbl[2]  = '{8'd255, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255};
        tbl[3]  = '{8'd0,   8'd128, 8'd128, 8'd0,   8'd0,   8'd0};
        tbl[4]  = '{8'd16,  8'd128, 8'd240, 8'd201, 8'd0,   8'd0};
        tbl[5]  = '{8'd16,  8'd255, 8'd128, 8'd0,   8'd0,   8'd255};
        tbl[6]  = '{8'd126, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
        tbl[7]  = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd77,  8'd0};
        tbl[8]  = '{8'd0,   8'd0,   8'd255, 8'd209, 8'd0,   8'd0};
        tbl[9]  = '{8'd0,   8'd255, 8'd0,   8'd0,   8'd22,  8'd250};
        tbl[10] = '{8'd0,   8'd255, 8'd255, 8'd209, 8'd0,   8'd250};
        tbl[11] = '{8'd255, 8'd0,   8'd0,   8'd49,  8'd255, 8'd8};
        tbl[12] = '{8'd255, 8'd0,   8'd255, 8'd255, 8'd238, 8'd8};
        tbl[13] = '{8'd255, 8'd255, 8'd0,   8'd49,  8'd255, 8'd255};
        tbl[14] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd183, 8'd255};

        rst       = 1'b1;
        i_y_8b    = 8'd200;
        i_cb_8b   = 8'd50;
        i_cr_8b   = 8'd220;
        i_h_sync  = 1'b1;
        i_v_sync  = 1'b1;
        i_data_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_out("reset_state", i, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;

        for (int i = 0; i < 15; i++)
            push_pixel("vector", tbl[i].y, tbl[i].cb, tbl[i].cr, 1'b0, 1'b0, 1'b1,
                       tbl[i].r, tbl[i].g, tbl[i].b);

        // 1-cycle h, 3-cycle v, 5-cycle de, distinct pixel per cycle
        for (int k = 0; k < 8; k++)
            push_model("timing_align", 8'(40 + 20 * k), 8'(100 + 10 * k), 8'(150 - 10 * k),
                       k == 1, (k >= 1) && (k <= 3), (k >= 1) && (k <= 5));

        for (int i = 0; i < 1000; i++)
            push_model("stream", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Reset mid-stream: in-flight pixels are dropped, not flushed.
        i_y_8b    = 8'd235;
        i_cb_8b   = 8'd128;
        i_cr_8b   = 8'd128;
        i_h_sync  = 1'b1;
        i_v_sync  = 1'b1;
        i_data_en = 1'b1;
        rst       = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_out("mid_reset", i, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 6; i++)
            push_pixel("post_reset", 8'd235, 8'd128, 8'd128, 1'b1, 1'b1, 1'b1,
                       8'd255, 8'd255, 8'd255);

        for (int i = 0; i < 4; i++)
            push_pixel("drain", 8'd16, 8'd128, 8'd128, 1'b0, 1'b0, 1'b0,
                       8'd0, 8'd0, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
